// File: rtl/icache_prefetch_buffer.sv
// Single-line next-line instruction prefetcher with a one-line stream buffer.
// Optional feature: define ICACHE_PF_CROSS_PAGE_EN to allow prefetches into the next 4 KB page.
module icache_prefetch_buffer #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [31:0]               req_addr,
    input  logic                      tag_hit,
    input  logic                      tag_valid,
    input  logic                      tag_work,
    input  logic                      pf_hit,
    input  logic                      pf_valid,
    input  logic [31:0]               lookup_addr,
    output logic                      buf_hit,
    output logic                      buf_pending,
    input  logic                      buf_take,
    output logic [32*LINE_WORDS-1:0]  buf_line,
    output logic                      tag_wen,
    output logic [20:0]               tag_wdata,
    output logic [IDX_W-1:0]          tag_index,
    input  logic                      flush,
    output logic                      mem_rreq,
    output logic [31:0]               mem_raddr,
    input  logic                      mem_rreq_ready,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_rlast,
    output logic [1:0]                dbg_state
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [26:0]       pf_line_q, pf_line_d;
    logic [31:0]       data_q [LINE_WORDS];
    logic [31:0]       data_d [LINE_WORDS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;

    logic line_match;
    logic page_ok;
    logic trigger;
    logic take_ok;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[4:0], lookup_addr[4:0]};

    assign line_match = (lookup_addr[31:5] == pf_line_q);

`ifdef ICACHE_PF_CROSS_PAGE_EN
    assign page_ok = 1'b1;
`else
    assign page_ok = (req_addr[11:5] != 7'h7F);
`endif

    // The top line of the address space has no successor, so it never triggers.
    assign trigger = (state_q == S_IDLE) && !flush && tag_work && req_valid &&
                     tag_hit && tag_valid && !(pf_hit && pf_valid) &&
                     (req_addr[31:5] != 27'h7FF_FFFF) && page_ok;

    // A flush in the same cycle as a take cancels the handover.
    assign take_ok = (state_q == S_FULL) && buf_take && line_match && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pf_line_q <= '0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) data_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pf_line_q <= pf_line_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            for (int i = 0; i < LINE_WORDS; i++) data_q[i] <= data_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        pf_line_d = pf_line_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        for (int i = 0; i < LINE_WORDS; i++) data_d[i] = data_q[i];
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    pf_line_d = req_addr[31:5] + 27'd1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) drop_d = 1'b1;
                if (mem_rreq_ready) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (flush) drop_d = 1'b1;
                if (mem_rvalid) begin
                    data_d[cnt_q] = mem_rdata;
                    cnt_d         = cnt_q + 1'b1;
                    // A short burst is a protocol error and leaves the buffer empty.
                    if (mem_rlast) begin
                        if (cnt_q == LAST_BEAT && !drop_d) state_d = S_FULL;
                        else                               state_d = S_IDLE;
                    end
                end
            end
            S_FULL: begin
                if (flush || take_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) drop_d = 1'b0;
    end

    always_comb begin
        mem_rreq    = 1'b0;
        mem_raddr   = '0;
        buf_hit     = 1'b0;
        buf_pending = 1'b0;
        tag_wen     = 1'b0;
        tag_wdata   = '0;
        tag_index   = '0;
        case (state_q)
            S_REQ: begin
                mem_rreq    = 1'b1;
                mem_raddr   = {pf_line_q, 5'b0};
                buf_pending = line_match && !drop_q;
            end
            S_FILL: begin
                buf_pending = line_match && !drop_q;
            end
            S_FULL: begin
                buf_hit = line_match;
                if (take_ok) begin
                    tag_wen   = 1'b1;
                    tag_index = pf_line_q[IDX_W-1:0];
                    tag_wdata = {1'b1, pf_line_q[26:7]};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        buf_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) buf_line[i*32 +: 32] = data_q[i];
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_icache_prefetch_buffer.sv
// Bench for icache_prefetch_buffer: directed vectors, a transaction-level model, literal pins.
module tb_icache_prefetch_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid, tag_hit, tag_valid, tag_work, pf_hit, pf_valid;
    logic [31:0]  req_addr, lookup_addr;
    logic         buf_hit, buf_pending, buf_take;
    logic [255:0] buf_line;
    logic         tag_wen;
    logic [20:0]  tag_wdata;
    logic [6:0]   tag_index;
    logic         flush, mem_rreq, mem_rreq_ready, mem_rvalid, mem_rlast;
    logic [31:0]  mem_raddr, mem_rdata;
    logic [1:0]   dbg_state;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;

    always #5 clk = ~clk;

    icache_prefetch_buffer #(.LINE_WORDS(8), .IDX_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr),
        .tag_hit(tag_hit), .tag_valid(tag_valid), .tag_work(tag_work),
        .pf_hit(pf_hit), .pf_valid(pf_valid),
        .lookup_addr(lookup_addr), .buf_hit(buf_hit), .buf_pending(buf_pending),
        .buf_take(buf_take), .buf_line(buf_line),
        .tag_wen(tag_wen), .tag_wdata(tag_wdata), .tag_index(tag_index),
        .flush(flush), .mem_rreq(mem_rreq), .mem_raddr(mem_raddr),
        .mem_rreq_ready(mem_rreq_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 empty, 1 asking memory, 2 receiving beats, 3 holding a line
    int          m_ph   = 0;
    logic [26:0] m_line = '0;
    bit          m_drop = 0;
    int          m_n    = 0;
    logic [31:0] m_w [8];

    function automatic bit trig_ok();
        bit page = 1;
`ifndef ICACHE_PF_CROSS_PAGE_EN
        page = (((req_addr >> 5) & 32'h7F) != 32'h7F);
`endif
        return req_valid && tag_work && tag_hit && tag_valid && !(pf_hit && pf_valid) &&
               ((req_addr >> 5) != 32'h07FF_FFFF) && page;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph   <= 0;
            m_line <= '0;
            m_drop <= 0;
            m_n    <= 0;
            for (int i = 0; i < 8; i++) m_w[i] <= '0;
        end else begin
            case (m_ph)
                0: if (!flush && trig_ok()) begin
                    m_line <= req_addr[31:5] + 27'd1;
                    m_ph   <= 1;
                end
                1: begin
                    if (flush) m_drop <= 1;
                    if (mem_rreq_ready) begin m_ph <= 2; m_n <= 0; end
                end
                2: begin
                    if (flush) m_drop <= 1;
                    if (mem_rvalid) begin
                        m_w[m_n % 8] <= mem_rdata;
                        m_n <= m_n + 1;
                        if (mem_rlast) begin
                            if (m_n == 7 && !m_drop && !flush) m_ph <= 3;
                            else begin m_ph <= 0; m_drop <= 0; end
                        end
                    end
                end
                3: if (flush || (buf_take && lookup_addr[31:5] == m_line)) m_ph <= 0;
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic         e_hit, e_pend, e_wen, match;
            logic [255:0] e_line;
            match  = (lookup_addr[31:5] == m_line);
            e_hit  = (m_ph == 3) && match;
            e_pend = (m_ph == 1 || m_ph == 2) && match && !m_drop;
            e_wen  = e_hit && buf_take && !flush;
            for (int i = 0; i < 8; i++) e_line[i*32 +: 32] = m_w[i];
            chk("mem_rreq",    256'(mem_rreq),    256'(m_ph == 1));
            chk("mem_raddr",   256'(mem_raddr),   (m_ph == 1) ? 256'({m_line, 5'b0}) : 256'(0));
            chk("buf_hit",     256'(buf_hit),     256'(e_hit));
            chk("buf_pending", 256'(buf_pending), 256'(e_pend));
            chk("tag_wen",     256'(tag_wen),     256'(e_wen));
            chk("tag_index",   256'(tag_index),   e_wen ? 256'(m_line[6:0]) : 256'(0));
            chk("tag_wdata",   256'(tag_wdata),   e_wen ? 256'({1'b1, m_line[26:7]}) : 256'(0));
            chk("buf_line",    buf_line,          e_line);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic trig(input logic [31:0] a, input logic work, input logic ph, input logic pv);
        req_valid = 1; req_addr = a; tag_hit = 1; tag_valid = 1;
        tag_work = work; pf_hit = ph; pf_valid = pv;
        cyc(1);
        req_valid = 0; tag_hit = 0; tag_valid = 0; tag_work = 0; pf_hit = 0; pf_valid = 0;
    endtask

    task automatic grant();
        mem_rreq_ready = 1;
        cyc(1);
        mem_rreq_ready = 0;
    endtask

    task automatic burst(input int n, input int flush_at, input int gap_at, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                mem_rvalid = 0; mem_rlast = 0; flush = 0;
                cyc(1);
            end
            mem_rvalid = 1;
            mem_rdata  = base + i;
            mem_rlast  = (i == n - 1);
            flush      = (i == flush_at);
            cyc(1);
        end
        mem_rvalid = 0; mem_rlast = 0; flush = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " mem_rreq"},    256'(mem_rreq),    256'(0));
        chk({tag, " mem_raddr"},   256'(mem_raddr),   256'(0));
        chk({tag, " buf_hit"},     256'(buf_hit),     256'(0));
        chk({tag, " buf_pending"}, 256'(buf_pending), 256'(0));
        chk({tag, " tag_wen"},     256'(tag_wen),     256'(0));
        chk({tag, " tag_wdata"},   256'(tag_wdata),   256'(0));
        chk({tag, " tag_index"},   256'(tag_index),   256'(0));
        chk({tag, " buf_line"},    buf_line,          256'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        req_valid = 0; req_addr = 0; tag_hit = 0; tag_valid = 0; tag_work = 0;
        pf_hit = 0; pf_valid = 0; lookup_addr = 0; buf_take = 0; flush = 0;
        mem_rreq_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rlast = 0;
        #2 rst = 0;
        started = 1;
        #1 check_all_zero("reset");
        cyc(2);
        rst = 1;
        cyc(1);

        // Next-line trigger, fill with a one-cycle gap, hand over.
        lookup_addr = 32'h1000_0060;
        trig(32'h1000_0040, 1, 0, 0);
        mem_rreq_ready = 1;
        to_neg();
        chk("s1 rreq",  256'(mem_rreq),  256'(1));
        chk("s1 raddr", 256'(mem_raddr), 256'(32'h1000_0060));
        sync();
        mem_rreq_ready = 0;
        to_neg();
        chk("s1 pending", 256'(buf_pending), 256'(1));
        sync();
        burst(8, -1, 3, 32'hA0);
        lookup_addr = 32'h1000_0064;
        to_neg();
        chk("s1 buf_hit", 256'(buf_hit), 256'(1));
        sync();
        buf_take = 1;
        to_neg();
        chk("s1 tag_wen",   256'(tag_wen),          256'(1));
        chk("s1 tag_index", 256'(tag_index),        256'(7'h03));
        chk("s1 tag_wdata", 256'(tag_wdata),        256'(21'h110000));
        chk("s1 word0",     256'(buf_line[31:0]),   256'(32'hA0));
        chk("s1 word7",     256'(buf_line[255:224]), 256'(32'hA7));
        sync();
        buf_take = 0;
        to_neg();
        chk("s1 idle buf_hit", 256'(buf_hit), 256'(0));
        sync();

        // No-trigger cases: prefetch already present, no work, top of address space.
        trig(32'h1000_0040, 1, 1, 1);
        to_neg(); chk("nt pf_hit", 256'(mem_rreq), 256'(0)); sync();
        trig(32'h1000_0040, 0, 0, 0);
        to_neg(); chk("nt work", 256'(mem_rreq), 256'(0)); sync();
        trig(32'hFFFF_FFE0, 1, 0, 0);
        to_neg(); chk("nt wrap", 256'(mem_rreq), 256'(0)); sync();

        // Page crossing.
        lookup_addr = 32'h0000_1000;
        trig(32'h0000_0FE0, 1, 0, 0);
        to_neg();
`ifdef ICACHE_PF_CROSS_PAGE_EN
        chk("pg rreq",  256'(mem_rreq),  256'(1));
        chk("pg raddr", 256'(mem_raddr), 256'(32'h0000_1000));
        sync();
        flush = 1;
        grant();
        flush = 0;
        burst(8, -1, -1, 32'hB0);
        to_neg();
        chk("pg dropped buf_hit", 256'(buf_hit), 256'(0));
`else
        chk("pg rreq", 256'(mem_rreq), 256'(0));
`endif
        sync();

        // Flush at beat 3: burst completes, line discarded.
        lookup_addr = 32'h2000_0020;
        trig(32'h2000_0000, 1, 0, 0);
        grant();
        burst(8, 3, -1, 32'hC0);
        to_neg();
        chk("fl buf_hit", 256'(buf_hit),     256'(0));
        chk("fl pending", 256'(buf_pending), 256'(0));
        chk("fl state",   256'(dbg_state),   256'(0));
        sync();

        // Flush and take together in FULL: no tag write.
        lookup_addr = 32'h5000_0020;
        trig(32'h5000_0000, 1, 0, 0);
        grant();
        burst(8, -1, 5, 32'hD0);
        flush = 1;
        buf_take = 1;
        to_neg();
        chk("ft buf_hit", 256'(buf_hit), 256'(1));
        chk("ft tag_wen", 256'(tag_wen), 256'(0));
        sync();
        flush = 0;
        buf_take = 0;
        to_neg();
        chk("ft after buf_hit", 256'(buf_hit), 256'(0));
        sync();

        // Protocol error: rlast on beat 5.
        lookup_addr = 32'h3000_0020;
        trig(32'h3000_0000, 1, 0, 0);
        grant();
        to_neg();
        chk("pe pending", 256'(buf_pending), 256'(1));
        sync();
        burst(6, -1, -1, 32'hE0);
        to_neg();
        chk("pe buf_hit", 256'(buf_hit),   256'(0));
        chk("pe state",   256'(dbg_state), 256'(0));
        sync();

        // Asynchronous reset mid-fill.
        lookup_addr = 32'h4000_0020;
        trig(32'h4000_0000, 1, 0, 0);
        grant();
        mem_rvalid = 1;
        mem_rdata  = 32'hF0F0_0001;
        cyc(3);
        mem_rvalid = 0;
        #2 rst = 0;
        #1 check_all_zero("arst");
        chk("arst state", 256'(dbg_state), 256'(0));
        cyc(1);
        rst = 1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
